lift_plant_model: RTL and testbench
===================================

Name: lift_plant_model

Overview:
- Synthesisable, parametrised N-floor lift plant emulator for the DE0 board.
- Stands in for the physical toy lift, so the lift controller can run hardware-in-loop with no lift attached.
- Integrates controller motor commands into a position counter. Drives active-low limit and per-floor sensors.
- Generates pseudo-random floor calls. A call cancels early when the lift stops at the called floor. A motor overrun fault is latched.

Parameters:
- N_FLOORS, 3, number of floors (2..8).
- FLOOR_PITCH, 45, position units between adjacent floors.
- SENSE_W, 4, half-width of each floor sensor window in units.
- TICK_CYCLES, 50, clocks per movement tick (50 = 1 us at 50 MHz).
- INIT_POS, 20, position after reset (0..MAX_POS).
- GAP_MIN, 2000, minimum ticks between calls.
- GAP_MASK, 16'h1FFF, mask applied to the LFSR for the extra random gap.
- CALL_MIN, 200, minimum call hold in ticks.
- CALL_MASK, 16'h03FF, mask applied to the LFSR for the extra random hold.
- LFSR_SEED, 16'hACE1, LFSR reset value. A value of 0 is replaced by 16'hACE1.

Ports:
- clock, in, 1, system clock.
- n_reset, in, 1, asynchronous active-low reset.
- enable_n, in, 1, motor enable, 0 = run.
- direction, in, 1, 1 = up, 0 = down.
- call_en, in, 1, 1 = random call generation active.
- pos_load, in, 1, synchronous load of pos_value into position.
- pos_value, in, PW, load value, clamped to MAX_POS.
- top_n, out, 1, 0 when position == MAX_POS.
- bottom_n, out, 1, 0 when position == 0.
- floor_n, out, N_FLOORS, bit k = 0 when |position - k*FLOOR_PITCH| <= SENSE_W.
- call_n, out, N_FLOORS, at most one bit low at any time.
- position, out, PW, current position; PW = $clog2(MAX_POS+1).
- tick, out, 1, one-clock pulse per movement tick.
- fault, out, 1, sticky motor overrun flag.

Behaviour:
- MAX_POS = (N_FLOORS-1)*FLOOR_PITCH. All position arithmetic is unsigned, PW bits wide.
- Reset values: position = INIT_POS; tick counter = 0; tick = 0; LFSR = seed; call FSM in GAP with the gap counter loaded to GAP_MIN; call_n all 1; fault = 0. Sensors are registered and reset to the decode of INIT_POS.
- Tick counter: counts 0..TICK_CYCLES-1. tick = 1 for the one clock in which the counter == TICK_CYCLES-1, and the counter wraps to 0 on that clock.
- Movement on a tick with enable_n = 0:
  - direction = 1 and position < MAX_POS: position + 1.
  - direction = 0 and position > 0: position - 1.
  - Otherwise position holds and fault is set (overrun into a limit).
- enable_n = 1: position holds.
- pos_load has priority over movement. It does not reset the tick counter and does not set fault.
- Sensors (top_n, bottom_n, floor_n) are registered decodes of position, so they lag position by exactly 1 clock. Floor windows never overlap, since SENSE_W < FLOOR_PITCH/2 (elaboration-time assertion).
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances once per tick, never otherwise.
- Call FSM, states IDLE, GAP, CALL. Counters decrement on ticks only.
  - IDLE: call_n all 1. Go to GAP when call_en = 1, loading the gap count as GAP_MIN + (lfsr & GAP_MASK).
  - GAP: on a tick with count == 0, go to CALL. Latch the floor as lfsr[7:0] % N_FLOORS, drive that call_n bit low, and load the hold count as CALL_MIN + (lfsr & CALL_MASK).
  - CALL: go to GAP (calls released, new gap count loaded) on a tick where either the hold count == 0, or the called floor's floor_n = 0 and enable_n = 1 (arrival cancel). Arrival cancel wins if both occur on the same tick.
  - Any state: call_en = 0 forces IDLE on the next clock and releases calls immediately.
- The fault flag clears only on n_reset.
- Reset asserted mid-movement or mid-call: all state returns to the reset values asynchronously.

Decomposition:
- Package lift_pkg holds:
  - the enum call_state_t {IDLE, GAP, CALL};
  - LFSR_TAPS = 16'hB400;
  - DEFAULT_SEED = 16'hACE1.
- Sub-module lift_call_gen contains the LFSR plus the call FSM. Its inputs are tick, call_en, enable_n and floor_n; its output is call_n.
- The top level contains the tick counter, the position integrator, the sensor decode and the fault logic.

Test Plan:
All scenarios use TICK_CYCLES = 2 and default floor parameters (MAX_POS = 90).
- Reset with INIT_POS = 20: position = 20, all sensors 1, call_n = 3'b111, fault = 0. The first tick pulse appears on the 2nd clock after reset release.
- Up run: enable_n = 0, direction = 1 from 20 -> after 25 ticks position = 45 and floor_n = 3'b101 one clock later. floor_n[1] is 0 for positions 41..49. At 90, top_n = 0.
- Overrun: at 90 hold enable_n = 0, direction = 1 for one tick -> position stays 90 and fault = 1. fault stays 1 after enable_n = 1, until n_reset.
- Bottom: pos_load with pos_value = 1, then one down tick -> position 0, bottom_n = 0, floor_n[0] = 0, fault = 0.
- Call timing: GAP_MIN = 3, GAP_MASK = 0, CALL_MIN = 5, CALL_MASK = 0, lift parked away from floors -> exactly one call_n bit low for 6 ticks, high for 4 ticks, repeating.
- Arrival cancel: with a call on floor 2 active, load position 88 and set enable_n = 1 -> call_n returns to 3'b111 on the next tick. Setting call_en = 0 mid-call releases the call within 1 clock.

Source files
------------

// File: rtl/lift_plant_model_pkg.sv
// Shared types and constants for the lift plant emulator.
package lift_pkg;

   typedef enum logic [1:0] {IDLE, GAP, CALL} call_state_t;

   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   // Galois step for x^16+x^14+x^13+x^11+1, shifting right.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/lift_plant_model_if.sv
// Controller <-> plant signal bundle; the controller side is the master.
interface lift_plant_model_if #(
   parameter int N_FLOORS = 3,
   parameter int PW       = 7
);
   import lift_pkg::*;

   // No handshake: commands are level-sampled every clock, sensors are active-low levels.
   logic                enable_n;
   logic                direction;
   logic                call_en;
   logic                pos_load;
   logic [PW-1:0]       pos_value;
   logic                top_n;
   logic                bottom_n;
   logic [N_FLOORS-1:0] floor_n;
   logic [N_FLOORS-1:0] call_n;
   logic [PW-1:0]       position;
   logic                tick;
   logic                fault;
   call_state_t         call_state;

   modport master (
      output enable_n, direction, call_en, pos_load, pos_value,
      input  top_n, bottom_n, floor_n, call_n, position, tick, fault, call_state
   );

   modport slave (
      input  enable_n, direction, call_en, pos_load, pos_value,
      output top_n, bottom_n, floor_n, call_n, position, tick, fault, call_state
   );

endinterface

// File: rtl/lift_plant_model_call_gen.sv
// Pseudo-random floor call generator: LFSR plus IDLE/GAP/CALL state machine.
module lift_call_gen
   import lift_pkg::*;
#(
   parameter int          N_FLOORS  = 3,
   parameter int          GAP_MIN   = 2000,
   parameter logic [15:0] GAP_MASK  = 16'h1FFF,
   parameter int          CALL_MIN  = 200,
   parameter logic [15:0] CALL_MASK = 16'h03FF,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                clock,
   input  logic                n_reset,
   input  logic                i_tick,
   input  logic                i_call_en,
   input  logic                i_enable_n,
   input  logic [N_FLOORS-1:0] i_floor_n,
   output logic [N_FLOORS-1:0] o_call_n,
   output call_state_t         o_state
);

   localparam int          FW   = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
   localparam int          CW   = 17;
   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? DEFAULT_SEED : LFSR_SEED;

   call_state_t   r_state, w_state_nxt;
   logic [15:0]   r_lfsr;
   logic [CW-1:0] r_cnt, w_cnt_nxt, w_gap_load, w_hold_load;
   logic [FW-1:0] r_floor, w_floor_nxt, w_floor_pick;
   logic          w_arrived;

   assign w_gap_load   = CW'(GAP_MIN) + CW'(r_lfsr & GAP_MASK);
   assign w_hold_load  = CW'(CALL_MIN) + CW'(r_lfsr & CALL_MASK);
   assign w_floor_pick = FW'(r_lfsr[7:0] % 8'(N_FLOORS));
   assign w_arrived    = ~i_floor_n[r_floor] & i_enable_n;
   assign o_state      = r_state;

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= GAP;
         r_cnt   <= CW'(GAP_MIN);
         r_floor <= '0;
         r_lfsr  <= SEED;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_floor <= w_floor_nxt;
         if (i_tick) r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_floor_nxt = r_floor;
      o_call_n    = '1;
      if (r_state == CALL && i_call_en) o_call_n = ~(N_FLOORS'(1) << r_floor);
      if (!i_call_en) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = GAP;
               w_cnt_nxt   = w_gap_load;
            end
            GAP: begin
               if (i_tick) begin
                  if (r_cnt == '0) begin
                     w_state_nxt = CALL;
                     w_floor_nxt = w_floor_pick;
                     w_cnt_nxt   = w_hold_load;
                  end else begin
                     w_cnt_nxt = r_cnt - CW'(1);
                  end
               end
            end
            CALL: begin
               // Arrival and hold expiry both end the call the same way.
               if (i_tick) begin
                  if (w_arrived || r_cnt == '0) begin
                     w_state_nxt = GAP;
                     w_cnt_nxt   = w_gap_load;
                  end else begin
                     w_cnt_nxt = r_cnt - CW'(1);
                  end
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/lift_plant_model.sv
// N-floor lift plant emulator: tick timebase, position integrator, sensors,
// overrun fault and random floor calls for hardware-in-loop controller tests.
module lift_plant_model
   import lift_pkg::*;
#(
   parameter int          N_FLOORS    = 3,
   parameter int          FLOOR_PITCH = 45,
   parameter int          SENSE_W     = 4,
   parameter int          TICK_CYCLES = 50,
   parameter int          INIT_POS    = 20,
   parameter int          GAP_MIN     = 2000,
   parameter logic [15:0] GAP_MASK    = 16'h1FFF,
   parameter int          CALL_MIN    = 200,
   parameter logic [15:0] CALL_MASK   = 16'h03FF,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input logic               clock,
   input logic               n_reset,
   lift_plant_model_if.slave bus
);

   localparam int            MAX_POS   = (N_FLOORS - 1) * FLOOR_PITCH;
   localparam int            PW        = $clog2(MAX_POS + 1);
   localparam int            TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] MAX_P     = PW'(MAX_POS);
   localparam logic [PW-1:0] INIT_P    = PW'(INIT_POS);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

   if (!(SENSE_W < FLOOR_PITCH / 2)) begin : g_bad_window
      $error("SENSE_W must be below FLOOR_PITCH/2 so floor windows stay disjoint");
   end
   if (N_FLOORS < 2 || N_FLOORS > 8) begin : g_bad_floors
      $error("N_FLOORS must be in 2..8");
   end
   if (INIT_POS < 0 || INIT_POS > MAX_POS) begin : g_bad_init
      $error("INIT_POS must be in 0..MAX_POS");
   end

   function automatic logic [N_FLOORS-1:0] floor_decode(input logic [PW-1:0] p);
      logic [N_FLOORS-1:0] f;
      int                  d;
      f = '1;
      for (int k = 0; k < N_FLOORS; k++) begin
         d = int'(p) - k * FLOOR_PITCH;
         if (d <= SENSE_W && d >= -SENSE_W) f[k] = 1'b0;
      end
      return f;
   endfunction

   logic [TW-1:0]       r_tcnt;
   logic [PW-1:0]       r_pos;
   logic                r_fault;
   logic                r_top_n, r_bottom_n;
   logic [N_FLOORS-1:0] r_floor_n;
   logic                w_tick, w_run, w_at_limit;
   logic [PW-1:0]       w_load_val;
   logic [N_FLOORS-1:0] w_call_n;

   assign w_tick     = (r_tcnt == TICK_LAST);
   assign w_load_val = (bus.pos_value > MAX_P) ? MAX_P : bus.pos_value;
   assign w_run      = w_tick && !bus.enable_n && !bus.pos_load;
   assign w_at_limit = bus.direction ? (r_pos == MAX_P) : (r_pos == '0);

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) r_tcnt <= '0;
      else          r_tcnt <= w_tick ? '0 : r_tcnt + TW'(1);
   end

   // A load beats movement and never raises the fault.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         r_pos   <= INIT_P;
         r_fault <= 1'b0;
      end else if (bus.pos_load) begin
         r_pos <= w_load_val;
      end else if (w_run) begin
         if (w_at_limit)         r_fault <= 1'b1;
         else if (bus.direction) r_pos   <= r_pos + PW'(1);
         else                    r_pos   <= r_pos - PW'(1);
      end
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         r_top_n    <= (INIT_P != MAX_P);
         r_bottom_n <= (INIT_P != '0);
         r_floor_n  <= floor_decode(INIT_P);
      end else begin
         r_top_n    <= (r_pos != MAX_P);
         r_bottom_n <= (r_pos != '0);
         r_floor_n  <= floor_decode(r_pos);
      end
   end

   lift_call_gen #(
      .N_FLOORS (N_FLOORS),
      .GAP_MIN  (GAP_MIN),
      .GAP_MASK (GAP_MASK),
      .CALL_MIN (CALL_MIN),
      .CALL_MASK(CALL_MASK),
      .LFSR_SEED(LFSR_SEED)
   ) u_call_gen (
      .clock     (clock),
      .n_reset   (n_reset),
      .i_tick    (w_tick),
      .i_call_en (bus.call_en),
      .i_enable_n(bus.enable_n),
      .i_floor_n (r_floor_n),
      .o_call_n  (w_call_n),
      .o_state   (bus.call_state)
   );

   assign bus.position = r_pos;
   assign bus.tick     = w_tick;
   assign bus.fault    = r_fault;
   assign bus.top_n    = r_top_n;
   assign bus.bottom_n = r_bottom_n;
   assign bus.floor_n  = r_floor_n;
   assign bus.call_n   = w_call_n;

endmodule

// File: tb/tb_lift_plant_model.sv
// Directed and randomized checks of the lift plant against a tick-indexed reference model.
`timescale 1ns/1ps
module tb_lift_plant_model;

   localparam int          N_FLOORS    = 3;
   localparam int          FLOOR_PITCH = 45;
   localparam int          SENSE_W     = 4;
   localparam int          TICK_CYCLES = 2;
   localparam int          INIT_POS    = 20;
   localparam int          GAP_MIN     = 3;
   localparam logic [15:0] GAP_MASK    = 16'h0000;
   localparam int          CALL_MIN    = 5;
   localparam logic [15:0] CALL_MASK   = 16'h0000;
   localparam logic [15:0] SEED        = 16'hACE1;
   localparam int          MAX_POS     = 90;
   localparam int          PW          = 7;
   localparam int          OW          = PW + 10;
   localparam int          M_IDLE = 0, M_GAP = 1, M_CALL = 2;

   logic clock   = 1'b0;
   logic n_reset = 1'b0;
   int   errors  = 0;
   int   checks  = 0;

   lift_plant_model_if #(.N_FLOORS(N_FLOORS), .PW(PW)) bus ();

   lift_plant_model #(
      .N_FLOORS(N_FLOORS), .FLOOR_PITCH(FLOOR_PITCH), .SENSE_W(SENSE_W),
      .TICK_CYCLES(TICK_CYCLES), .INIT_POS(INIT_POS), .GAP_MIN(GAP_MIN),
      .GAP_MASK(GAP_MASK), .CALL_MIN(CALL_MIN), .CALL_MASK(CALL_MASK), .LFSR_SEED(SEED)
   ) dut (
      .clock  (clock),
      .n_reset(n_reset),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   logic [15:0] lfsr_seq [0:8191];
   int   m_ticks, m_tcnt, m_pos, m_prev_pos, m_mode, m_due, m_floor;
   logic m_fault, m_tick;
   logic [OW-1:0] exp_q [$];

   assign m_tick = (m_tcnt == TICK_CYCLES - 1);

   function automatic logic [N_FLOORS-1:0] exp_floor_n(input int p);
      exp_floor_n = '1;
      for (int k = 0; k < N_FLOORS; k++)
         if ((p - k * FLOOR_PITCH <= SENSE_W) && (k * FLOOR_PITCH - p <= SENSE_W))
            exp_floor_n[k] = 1'b0;
   endfunction

   function automatic logic [N_FLOORS-1:0] exp_call_n();
      if (m_mode == M_CALL && bus.call_en) return ~(N_FLOORS'(1) << m_floor);
      return '1;
   endfunction

   function automatic int cur_lfsr();
      return int'(lfsr_seq[m_ticks % 8192]);
   endfunction

   function automatic logic [OW-1:0] exp_vec();
      return {PW'(m_pos), m_tick, logic'(m_prev_pos != MAX_POS), logic'(m_prev_pos != 0),
              exp_floor_n(m_prev_pos), exp_call_n(), m_fault};
   endfunction

   always @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         m_ticks <= 0; m_tcnt <= 0; m_pos <= INIT_POS; m_prev_pos <= INIT_POS;
         m_fault <= 1'b0; m_mode <= M_GAP; m_due <= GAP_MIN + 1; m_floor <= 0;
      end else begin
         m_tcnt <= m_tick ? 0 : m_tcnt + 1;
         if (m_tick) m_ticks <= m_ticks + 1;
         m_prev_pos <= m_pos;
         if (bus.pos_load) begin
            m_pos <= (int'(bus.pos_value) > MAX_POS) ? MAX_POS : int'(bus.pos_value);
         end else if (m_tick && !bus.enable_n) begin
            if (bus.direction && m_pos < MAX_POS)  m_pos <= m_pos + 1;
            else if (!bus.direction && m_pos > 0) m_pos <= m_pos - 1;
            else                                   m_fault <= 1'b1;
         end
         // m_due is the index of the tick on which the current phase ends.
         if (!bus.call_en) begin
            m_mode <= M_IDLE;
         end else if (m_mode == M_IDLE) begin
            m_mode <= M_GAP;
            m_due  <= m_ticks + (m_tick ? 2 : 1) + GAP_MIN + (cur_lfsr() & int'(GAP_MASK));
         end else if (m_tick && m_mode == M_GAP && m_ticks + 1 == m_due) begin
            m_mode  <= M_CALL;
            m_floor <= (cur_lfsr() & 255) % N_FLOORS;
            m_due   <= m_ticks + 2 + CALL_MIN + (cur_lfsr() & int'(CALL_MASK));
         end else if (m_tick && m_mode == M_CALL &&
                      ((((exp_floor_n(m_prev_pos) >> m_floor) & 1) == 0 && bus.enable_n) ||
                       m_ticks + 1 == m_due)) begin
            m_mode <= M_GAP;
            m_due  <= m_ticks + 2 + GAP_MIN + (cur_lfsr() & int'(GAP_MASK));
         end
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bus.enable_n = 1'b1; bus.direction = 1'b1; bus.call_en = 1'b0;
      bus.pos_load = 1'b0; bus.pos_value = '0;
      n_reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if (bus.position !== 7'd20) begin errors++; $display("FAIL reset_position: got %0d want 20", bus.position); end
      checks++; if ({bus.top_n, bus.bottom_n, bus.floor_n} !== 5'b11111) begin errors++; $display("FAIL reset_sensors: got %b want 11111", {bus.top_n, bus.bottom_n, bus.floor_n}); end
      checks++; if (bus.call_n !== 3'b111) begin errors++; $display("FAIL reset_call_n: got %b want 111", bus.call_n); end
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
      n_reset = 1'b1;
      #1;
      checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick0: got %b want 0", bus.tick); end
      @(negedge clock);
      checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL first_tick: got %b want 1", bus.tick); end
      @(negedge clock);
      checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL tick_pulse_width: got %b want 0", bus.tick); end
   endtask

   task automatic test_up_run();
      int moved = 0;
      int cyc   = 0;
      bus.enable_n = 1'b0; bus.direction = 1'b1;
      while (moved < 25 && cyc < 200) begin
         if (bus.tick) moved++;
         @(negedge clock); cyc++;
         checks++; if ({bus.position, bus.floor_n} !== {PW'(m_pos), exp_floor_n(m_prev_pos)}) begin errors++; $display("FAIL up_track: got %0d/%b want %0d/%b", bus.position, bus.floor_n, m_pos, exp_floor_n(m_prev_pos)); end
      end
      checks++; if (bus.position !== 7'd45) begin errors++; $display("FAIL up_25_ticks: got %0d want 45", bus.position); end
      @(negedge clock);
      checks++; if (bus.floor_n !== 3'b101) begin errors++; $display("FAIL floor1_sensor: got %b want 101", bus.floor_n); end
      cyc = 0;
      while (bus.position !== 7'd90 && cyc < 400) begin
         @(negedge clock); cyc++;
         checks++; if (bus.floor_n[1] !== !(m_prev_pos >= 41 && m_prev_pos <= 49)) begin errors++; $display("FAIL floor1_window: got %b at prev pos %0d", bus.floor_n[1], m_prev_pos); end
      end
      bus.enable_n = 1'b1;
      checks++; if (bus.position !== 7'd90) begin errors++; $display("FAIL reach_top: got %0d want 90", bus.position); end
      @(negedge clock);
      checks++; if (bus.top_n !== 1'b0) begin errors++; $display("FAIL top_n: got %b want 0", bus.top_n); end
   endtask

   task automatic test_overrun();
      int cyc = 0;
      bus.enable_n = 1'b0; bus.direction = 1'b1;
      while (!bus.tick && cyc < 10) begin @(negedge clock); cyc++; end
      @(negedge clock);
      bus.enable_n = 1'b1;
      checks++; if (bus.position !== 7'd90) begin errors++; $display("FAIL overrun_hold: got %0d want 90", bus.position); end
      checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL overrun_fault: got %b want 1", bus.fault); end
      repeat (6) @(negedge clock);
      checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b want 1", bus.fault); end
      n_reset = 1'b0;
      #1;
      checks++; if ({bus.position, bus.fault} !== {7'd20, 1'b0}) begin errors++; $display("FAIL async_reset: got %0d/%b want 20/0", bus.position, bus.fault); end
      @(negedge clock);
      n_reset = 1'b1;
   endtask

   task automatic test_bottom();
      int cyc = 0;
      bus.pos_load = 1'b1; bus.pos_value = 7'd127;
      @(negedge clock);
      bus.pos_load = 1'b0;
      checks++; if ({bus.position, bus.fault} !== {7'd90, 1'b0}) begin errors++; $display("FAIL load_clamp: got %0d/%b want 90/0", bus.position, bus.fault); end
      bus.pos_load = 1'b1; bus.pos_value = 7'd1;
      @(negedge clock);
      bus.pos_load = 1'b0;
      checks++; if (bus.position !== 7'd1) begin errors++; $display("FAIL load_one: got %0d want 1", bus.position); end
      bus.enable_n = 1'b0; bus.direction = 1'b0;
      while (!bus.tick && cyc < 10) begin @(negedge clock); cyc++; end
      @(negedge clock);
      bus.enable_n = 1'b1;
      checks++; if ({bus.position, bus.fault} !== {7'd0, 1'b0}) begin errors++; $display("FAIL down_to_zero: got %0d/%b want 0/0", bus.position, bus.fault); end
      @(negedge clock);
      checks++; if ({bus.bottom_n, bus.floor_n[0]} !== 2'b00) begin errors++; $display("FAIL bottom_sensors: got %b want 00", {bus.bottom_n, bus.floor_n[0]}); end
   endtask

   task automatic test_call_timing();
      int  run_len = 0;
      bit  run_low = 1'b0;
      bit  first   = 1'b1;
      bit  low;
      bus.pos_load = 1'b1; bus.pos_value = 7'd22;
      @(negedge clock);
      bus.pos_load = 1'b0; bus.call_en = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         checks++; if (bus.call_n !== exp_call_n()) begin errors++; $display("FAIL call_model: got %b want %b", bus.call_n, exp_call_n()); end
         if (bus.tick) begin
            low = (bus.call_n != 3'b111);
            if (low && $countones(~bus.call_n) != 1) begin errors++; $display("FAIL call_onehot: got %b want one low bit", bus.call_n); end
            if (run_len > 0 && low != run_low) begin
               if (!first) begin
                  checks++; if (run_len != (run_low ? 6 : 4)) begin errors++; $display("FAIL call_run_len: got %0d want %0d", run_len, run_low ? 6 : 4); end
               end
               first = 1'b0; run_len = 0;
            end
            run_low = low; run_len++;
         end
      end
   endtask

   task automatic test_arrival_cancel();
      int cyc = 0;
      while (bus.call_n !== 3'b011 && cyc < 4000) begin @(negedge clock); cyc++; end
      checks++; if (bus.call_n !== 3'b011) begin errors++; $display("FAIL wait_floor2_call: got %b want 011", bus.call_n); end
      bus.pos_load = 1'b1; bus.pos_value = 7'd88; bus.enable_n = 1'b1;
      @(negedge clock);
      bus.pos_load = 1'b0;
      cyc = 0;
      while (bus.call_n !== 3'b111 && cyc < 5) begin
         @(negedge clock); cyc++;
         checks++; if (bus.call_n !== exp_call_n()) begin errors++; $display("FAIL cancel_model: got %b want %b", bus.call_n, exp_call_n()); end
      end
      checks++; if (bus.call_n !== 3'b111) begin errors++; $display("FAIL arrival_cancel: got %b want 111", bus.call_n); end
      cyc = 0;
      while (bus.call_n === 3'b111 && cyc < 4000) begin @(negedge clock); cyc++; end
      checks++; if (bus.call_n === 3'b111) begin errors++; $display("FAIL wait_any_call: got %b want one low bit", bus.call_n); end
      bus.call_en = 1'b0;
      @(negedge clock);
      checks++; if (bus.call_n !== 3'b111) begin errors++; $display("FAIL call_en_release: got %b want 111", bus.call_n); end
      repeat (20) @(negedge clock);
      checks++; if (bus.call_n !== 3'b111) begin errors++; $display("FAIL idle_no_call: got %b want 111", bus.call_n); end
   endtask

   task automatic test_random();
      logic [OW-1:0] exp_v;
      logic [OW-1:0] act_v;
      bus.call_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         exp_q.push_back(exp_vec());
         act_v = {bus.position, bus.tick, bus.top_n, bus.bottom_n, bus.floor_n, bus.call_n, bus.fault};
         exp_v = exp_q.pop_front();
         checks++; if (act_v !== exp_v) begin errors++; $display("FAIL random_cycle_%0d: got %h want %h", c, act_v, exp_v); end
         if ($urandom_range(0, 19) == 0) bus.enable_n  = ~bus.enable_n;
         if ($urandom_range(0, 40) == 0) bus.direction = ~bus.direction;
         bus.pos_load  = ($urandom_range(0, 60) == 0);
         bus.pos_value = PW'($urandom_range(0, 127));
         bus.call_en   = ($urandom_range(0, 50) != 0);
         n_reset       = !(c >= 1500 && c < 1502);
      end
      n_reset = 1'b1;
   endtask

   initial begin
      lfsr_seq[0] = SEED;
      for (int j = 1; j < 8192; j++)
         lfsr_seq[j] = (lfsr_seq[j-1] >> 1) ^
                       (lfsr_seq[j-1][0] ? ((16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10)) : 16'h0);
      test_reset();
      test_up_run();
      test_overrun();
      test_bottom();
      test_call_timing();
      test_arrival_cancel();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
